// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: scheduler state encoding and UART frame constants
package uart_tx_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, SEND, RELEASE} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts one start/8-data/stop frame onto tx, CLKS_PER_BIT cycles per bit
module uart_tx_serializer
  import uart_tx_scheduler_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk_25mhz,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 idle
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic                  active;
  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  bit_done;
  assign bit_done = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign idle = !active;
  assign tx = shreg[0];
  // Shift register refills with ones, so tx rests at the stop level between frames and after reset
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      active <= 1'b0;
      baud_cnt <= '0;
      bit_idx <= '0;
      shreg <= '1;
    end else if (load && !active) begin
      active <= 1'b1;
      baud_cnt <= '0;
      bit_idx <= '0;
      shreg <= {STOP_BIT, data, START_BIT};
    end else if (active) begin
      baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
      if (bit_done) begin
        active <= bit_idx != 4'(FRAME_BITS - 1);
        bit_idx <= bit_idx + 1'b1;
        shreg <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
      end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter granting whole messages from NUM_REQ byte streams onto one UART line
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int IDLE_TIMEOUT = 65535,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int TW = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                 clk_25mhz,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);
  state_t                 state, state_nxt;
  logic [GW-1:0]          last_grant, pick, cand;
  logic [DATA_BITS-1:0]   sel_data;
  logic [TW-1:0]          to_cnt;
  logic                   last_q, ser_idle, hs, starve, timeout;
  assign hs = state == GRANT && ser_idle && req_valid[grant_id];
  assign starve = state == GRANT && !req_valid[grant_id];
  assign timeout = starve && to_cnt >= TW'(IDLE_TIMEOUT - 1);
  // Walk candidates from farthest to nearest so the first valid one after last_grant wins
  always_comb begin
    pick = last_grant;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end
  // Byte of the current holder
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant_id == GW'(i)) sel_data = req_data[8*i +: 8];
  end
  // Next state and the grant-qualified outputs; a holder keeps the line until its last byte or a timeout
  always_comb begin
    state_nxt = state == IDLE  ? (enable && |req_valid ? GRANT : IDLE)
              : state == GRANT ? (hs ? SEND : timeout ? RELEASE : GRANT)
              : state == SEND  ? (ser_idle ? (last_q ? RELEASE : GRANT) : SEND)
              : IDLE;
    req_ready = (state == GRANT && ser_idle) ? NUM_REQ'(1) << grant_id : '0;
    busy = state != IDLE || !ser_idle;
  end
  // State, grant bookkeeping and the saturating starvation counter
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      last_q <= 1'b0;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GRANT) grant_id <= pick;
      if (hs) last_q <= req_last[grant_id];
      if (state == RELEASE) last_grant <= grant_id;
      to_cnt <= starve ? (&to_cnt ? to_cnt : to_cnt + 1'b1) : '0;
    end
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk_25mhz(clk_25mhz),
    .rst_n(rst_n),
    .load(hs),
    .data(sel_data),
    .tx(tx),
    .idle(ser_idle)
  );
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios for the UART message scheduler
module tb_uart_tx_scheduler;
  localparam int NR = 4;
  localparam int CPB = 434;
  localparam int TO = 40;
  logic clk_25mhz = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_last = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic tx, busy;
  logic [1:0] grant_id;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  byte unsigned qd[NR][$];
  bit ql[NR][$];
  byte unsigned rx_data[$];
  bit rx_ok[$];
  int rx_start[$];
  int glog[$];
  logic [NR-1:0] prev_ready = '0;
  int mon_pos = -1;
  int mon_start = 0;
  logic [9:0] mon_bits = '1;
  bit mon_bad = 0;

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(TO)) dut (
    .clk_25mhz(clk_25mhz),
    .rst_n(rst_n),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx(tx),
    .busy(busy),
    .grant_id(grant_id)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  initial begin
    #6000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // UART receiver: every cycle of each bit must hold the value seen on its first cycle
  always @(negedge clk_25mhz) begin
    cyc++;
    if (!rst_n) mon_pos = -1;
    else begin
      if (mon_pos < 0 && !tx) begin
        mon_pos = 0;
        mon_start = cyc;
        mon_bits = '1;
        mon_bad = 0;
      end
      if (mon_pos >= 0) begin
        if (mon_pos % CPB == 0) mon_bits[4'(mon_pos / CPB)] = tx;
        else if (tx !== mon_bits[4'(mon_pos / CPB)]) mon_bad = 1;
        if (mon_pos == 10 * CPB - 1) begin
          rx_data.push_back(mon_bits[8:1]);
          rx_ok.push_back(!mon_bad && !mon_bits[0] && mon_bits[9]);
          rx_start.push_back(mon_start);
          mon_pos = -1;
        end else mon_pos++;
      end
    end
  end

  task automatic present(int i);
    if (qd[i].size() > 0) begin
      req_valid[i] = 1'b1;
      req_data[8*i +: 8] = qd[i].pop_front();
      req_last[i] = ql[i].pop_front();
    end else begin
      req_valid[i] = 1'b0;
      req_last[i] = 1'b0;
    end
  endtask

  task automatic send(int i, byte unsigned d, bit l);
    qd[i].push_back(d);
    ql[i].push_back(l);
    if (!req_valid[i]) present(i);
  endtask

  task automatic step();
    logic [NR-1:0] hs;
    hs = req_valid & req_ready;
    @(negedge clk_25mhz);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) present(i);
    if (req_ready != '0 && prev_ready == '0)
      for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
    prev_ready = req_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    glog.delete();
    rx_data.delete();
    rx_ok.delete();
    rx_start.delete();
    prev_ready = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    req_valid = '1;
    repeat (3) step();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    do_reset();
  endtask

  task automatic test_single();
    int t, hs_cyc;
    do_reset();
    enable = 1'b1;
    send(0, 8'h48, 1'b1);
    t = 0;
    while (!(req_valid[0] && req_ready[0]) && t < 20) begin step(); t++; end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_before_hs: got %b want 1", tx); end
    hs_cyc = cyc;
    step();
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_start_fall: got %b want 0", tx); end
    t = 0;
    while (rx_data.size() == 0 && t < 11 * CPB) begin step(); t++; end
    total++;
    if (rx_data.size() != 1) begin bad++; $display("FAIL single_frame: got %0d frames want 1", rx_data.size()); end
    else if (rx_data[0] !== 8'h48 || !rx_ok[0] || rx_start[0] != hs_cyc + 1) begin
      bad++; $display("FAIL single_frame: got byte %h ok %0d start %0d want 48 1 %0d", rx_data[0], rx_ok[0], rx_start[0], hs_cyc + 1);
    end
    step();
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold: got %b want 1", busy); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_clear: got %b want 0", busy); end
    total++; if (tx !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL single_idle: got tx %b id %0d want 1 0", tx, grant_id); end
  endtask

  task automatic test_round_robin();
    int t;
    do_reset();
    enable = 1'b1;
    send(1, 8'h31, 1'b1);
    send(2, 8'h32, 1'b1);
    t = 0;
    while (rx_data.size() < 2 && t < 25 * CPB) begin step(); t++; end
    total++;
    if (rx_data.size() != 2 || rx_data[0] !== 8'h31 || rx_data[1] !== 8'h32) begin
      bad++; $display("FAIL rr_bytes: got %0d frames want 31 then 32", rx_data.size());
    end
    total++;
    if (glog.size() < 2 || glog[0] != 1 || glog[1] != 2) begin
      bad++; $display("FAIL rr_order: got %0d grants want 1 then 2", glog.size());
    end
    send(0, 8'h30, 1'b1);
    send(1, 8'h31, 1'b1);
    send(2, 8'h32, 1'b1);
    t = 0;
    while (glog.size() < 3 && t < 50) begin step(); t++; end
    total++;
    if (glog.size() < 3 || glog[2] != 0) begin bad++; $display("FAIL rr_wrap: got %0d grants want third grant to 0", glog.size()); end
    else if (grant_id !== 2'd0) begin bad++; $display("FAIL rr_wrap: got id %0d want 0", grant_id); end
  endtask

  task automatic test_atomic();
    int t, leak;
    do_reset();
    enable = 1'b1;
    send(0, 8'h48, 1'b0);
    send(0, 8'h69, 1'b0);
    send(0, 8'h0A, 1'b1);
    send(3, 8'h33, 1'b1);
    t = 0;
    leak = 0;
    while (rx_data.size() < 3 && t < 35 * CPB) begin
      step();
      t++;
      if (req_ready[3]) leak++;
    end
    total++; if (leak != 0) begin bad++; $display("FAIL atomic_leak: got %0d cycles of ready[3] want 0", leak); end
    total++;
    if (rx_data.size() != 3 || rx_data[0] !== 8'h48 || rx_data[1] !== 8'h69 || rx_data[2] !== 8'h0A || !rx_ok[2]) begin
      bad++; $display("FAIL atomic_bytes: got %0d frames want 48 69 0a", rx_data.size());
    end
    t = 0;
    while (req_ready !== 4'b1000 && t < 10) begin step(); t++; end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL atomic_next: got %b want 1000", req_ready); end
  endtask

  task automatic test_timeout();
    int t, n;
    do_reset();
    enable = 1'b1;
    send(2, 8'hA5, 1'b0);
    send(3, 8'h3C, 1'b1);
    t = 0;
    while (rx_data.size() == 0 && t < 12 * CPB) begin step(); t++; end
    total++;
    if (rx_data.size() != 1 || rx_data[0] !== 8'hA5) begin bad++; $display("FAIL timeout_byte: got %0d frames want one a5", rx_data.size()); end
    t = 0;
    n = 0;
    while (req_ready !== 4'b1000 && t < TO + 20) begin
      step();
      t++;
      if (req_ready === 4'b0100) n++;
    end
    total++; if (n != TO) begin bad++; $display("FAIL timeout_hold: got %0d cycles want %0d", n, TO); end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL timeout_regrant: got %b want 1000", req_ready); end
    total++; if (t != TO + 4) begin bad++; $display("FAIL timeout_gap: got %0d want %0d", t, TO + 4); end
  endtask

  task automatic test_reset_mid();
    int t, lows;
    do_reset();
    enable = 1'b1;
    send(1, 8'h00, 1'b1);
    t = 0;
    while (!(req_valid[1] && req_ready[1]) && t < 20) begin step(); t++; end
    repeat (1 + 5 * CPB + CPB / 2) step();
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit4: got %b want 0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx_async: got %b want 1", tx); end
    total++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rstmid_outputs: got busy %b ready %b want 0 0000", busy, req_ready); end
    step();
    rst_n = 1'b1;
    lows = 0;
    repeat (2 * CPB) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || rx_data.size() != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d low cycles %0d frames want 0 0", lows, rx_data.size()); end
    send(1, 8'h5A, 1'b1);
    t = 0;
    while (rx_data.size() == 0 && t < 12 * CPB) begin step(); t++; end
    total++;
    if (rx_data.size() != 1 || rx_data[0] !== 8'h5A || !rx_ok[0]) begin bad++; $display("FAIL rstmid_resume: got %0d frames want one 5a", rx_data.size()); end
  endtask

  task automatic test_enable();
    int t, act;
    do_reset();
    send(0, 8'hC3, 1'b0);
    send(0, 8'h3C, 1'b1);
    send(1, 8'h11, 1'b1);
    send(2, 8'h22, 1'b1);
    send(3, 8'h33, 1'b1);
    act = 0;
    repeat (60) begin
      step();
      if (req_ready != '0 || tx !== 1'b1 || busy !== 1'b0) act++;
    end
    total++; if (act != 0) begin bad++; $display("FAIL enable_low_idle: got %0d active cycles want 0", act); end
    enable = 1'b1;
    t = 0;
    while (req_ready === 4'b0000 && t < 10) begin step(); t++; end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL enable_grant: got %b want 0001", req_ready); end
    step();
    enable = 1'b0;
    t = 0;
    while (rx_data.size() < 2 && t < 25 * CPB) begin step(); t++; end
    total++;
    if (rx_data.size() != 2 || rx_data[0] !== 8'hC3 || rx_data[1] !== 8'h3C) begin bad++; $display("FAIL enable_msg: got %0d frames want c3 3c", rx_data.size()); end
    repeat (50) step();
    total++; if (busy !== 1'b0 || req_ready !== 4'b0000 || glog.size() != 2) begin
      bad++; $display("FAIL enable_stop: got busy %b ready %b grants %0d want 0 0000 2", busy, req_ready, glog.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_atomic();
    test_timeout();
    test_reset_mid();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
